// File: rtl/sub_share_pkg.sv
// Shared definitions for the subtractor-sharing arbiter: FSM encoding and
// the width helper used to size requester ids.
package sub_share_pkg;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // Bits needed to index n items; n is expected to be at least 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Request/response bundle between the requesters, the shared subtractor and
// its consumer. master = requester/consumer side, slave = arbiter side.
interface sub_share_arbiter_if
  import sub_share_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int Abitwidth = 21,
  parameter int Bbitwidth = 21,
  parameter int Sbitwidth = 22
);

  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*Abitwidth-1:0] req_a;
  logic [NREQ*Bbitwidth-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [Sbitwidth-1:0]      rsp_diff;
  logic [IDW-1:0]            rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_diff, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_diff, rsp_id
  );

endinterface

// File: rtl/GenericSubtractor.sv
// Combinational A - B with both operands zero-extended; the result wraps
// modulo 2^Sbitwidth, with no saturation and no overflow flag.
module GenericSubtractor #(
  parameter int Abitwidth = 21,
  parameter int Bbitwidth = 21,
  parameter int Sbitwidth = 22
) (
  input  logic [Abitwidth-1:0] A,
  input  logic [Bbitwidth-1:0] B,
  output logic [Sbitwidth-1:0] S
);

  assign S = Sbitwidth'(A) - Sbitwidth'(B);

endmodule

// File: rtl/sub_share_arbiter_rr.sv
// Round-robin picker: grants the first set request at or after ptr_i,
// wrapping NREQ-1 -> 0. Purely combinational; no grant while en_i is low.
module rr_arbiter
  import sub_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr + k never overflows before the wrap.
      pos = {1'b0, ptr_i} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) begin
        pos = pos - (IDW+1)'(NREQ);
      end
      if (en_i && !any_o && req_i[pos[IDW-1:0]]) begin
        any_o             = 1'b1;
        gnt_o[pos[IDW-1:0]] = 1'b1;
        idx_o             = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one subtractor among NREQ requesters: round-robin grant, result one cycle
// after transfer; grants only while the output register is empty or draining.
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int Abitwidth = 21,
  parameter int Bbitwidth = 21,
  parameter int Sbitwidth = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sub_share_arbiter_if.slave    bus
);

  localparam int IDW = clog2(NREQ);

  logic                 state_q, state_d;
  logic [Sbitwidth-1:0] rsp_diff_q, rsp_diff_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic                 accept;
  logic                 arb_en;
  logic                 transfer;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  logic [Abitwidth-1:0] op_a;
  logic [Bbitwidth-1:0] op_b;
  logic [Sbitwidth-1:0] sub_s;

  // Accept while empty, or while the held result leaves this cycle.
  assign accept = (state_q == ST_EMPTY) | (bus.rsp_ready & (state_q == ST_FULL));
  assign arb_en = accept & rst_n;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (bus.req_valid),
    .en_i  (arb_en),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // A grant is only ever issued to a valid requester, so grant == transfer.
  assign transfer = gnt_any;

  assign op_a = bus.req_a[int'(gnt_idx)*Abitwidth +: Abitwidth];
  assign op_b = bus.req_b[int'(gnt_idx)*Bbitwidth +: Bbitwidth];

  GenericSubtractor #(
    .Abitwidth (Abitwidth),
    .Bbitwidth (Bbitwidth),
    .Sbitwidth (Sbitwidth)
  ) u_sub (
    .A (op_a),
    .B (op_b),
    .S (sub_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (transfer)                    state_d = ST_FULL;
      ST_FULL:  if (!transfer && bus.rsp_ready)  state_d = ST_EMPTY;
      default:                                   state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    bus.req_ready = gnt;
    rsp_diff_d    = rsp_diff_q;
    rsp_id_d      = rsp_id_q;
    ptr_d         = ptr_q;
    if (transfer) begin
      rsp_diff_d = sub_s;
      rsp_id_d   = gnt_idx;
      ptr_d      = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_diff  = rsp_diff_q;
  assign bus.rsp_id    = rsp_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_diff_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      rsp_diff_q <= rsp_diff_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level model of the
// arbitration rules; inputs change on the falling edge, outputs sampled 1ns later.
module tb_sub_share_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 21;
  localparam int BW   = 21;
  localparam int SW   = 22;

  logic clk;
  logic rst_n;

  sub_share_arbiter_if #(.NREQ(NREQ), .Abitwidth(AW), .Bbitwidth(BW), .Sbitwidth(SW)) bus();

  sub_share_arbiter #(.NREQ(NREQ), .Abitwidth(AW), .Bbitwidth(BW), .Sbitwidth(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the output register and pointer should hold.
  int            m_ptr  = 0;
  bit            m_full = 1'b0;
  logic [SW-1:0] m_diff = '0;
  logic [1:0]    m_id   = '0;

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_full && !bus.rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_op();
    logic [AW-1:0] r;
    case ($urandom_range(0, 3))
      0:       r = '0;
      1:       r = '1;
      default: r = AW'($urandom);
    endcase
    return r;
  endfunction

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    bus.req_a[i*AW +: AW] = a;
    bus.req_b[i*BW +: BW] = b;
  endtask

  // Apply the coming rising edge to the model, then advance to the falling edge.
  task automatic next_cycle();
    int     g;
    longint d;
    g = exp_grant();
    if (!rst_n) begin
      m_ptr = 0; m_full = 1'b0; m_diff = '0; m_id = '0;
    end else if (g >= 0) begin
      d      = longint'(bus.req_a[g*AW +: AW]) - longint'(bus.req_b[g*BW +: BW]);
      m_diff = d[SW-1:0];
      m_id   = 2'(g);
      m_full = 1'b1;
      m_ptr  = (g + 1) % NREQ;
    end else if (m_full && bus.rsp_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready c%0d got %b want 0000", c, bus.req_ready); end
      n_vec++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_diff !== 22'd0 || bus.rsp_id !== 2'd0) begin
        n_err++;
        $display("FAIL reset_outputs c%0d got v=%b d=%h id=%0d want 0/0/0", c, bus.rsp_valid, bus.rsp_diff, bus.rsp_id);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b want 0001", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin
      n_err++; $display("FAIL reset_first_rsp got v=%b id=%0d want 1/0", bus.rsp_valid, bus.rsp_id);
    end
    next_cycle();
  endtask

  task automatic test_single();
    set_op(2, 21'd100, 21'd37);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_diff !== 22'd63 || bus.rsp_id !== 2'd2) begin
      n_err++; $display("FAIL single_rsp got v=%b d=%0d id=%0d want 1/63/2", bus.rsp_valid, bus.rsp_diff, bus.rsp_id);
    end
    next_cycle();
  endtask

  task automatic test_borrow();
    set_op(0, 21'd5, 21'd7);
    bus.req_valid = 4'b0001;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL borrow_ready got %b want 0001", bus.req_ready); end
    next_cycle();
    set_op(0, 21'h1FFFFF, 21'd0);
    #1;
    n_vec++;
    if (bus.rsp_diff !== 22'h3FFFFE || bus.rsp_id !== 2'd0) begin
      n_err++; $display("FAIL borrow_neg got d=%h id=%0d want 3ffffe/0", bus.rsp_diff, bus.rsp_id);
    end
    next_cycle();
    bus.req_valid = '0;
    #1;
    n_vec++;
    if (bus.rsp_diff !== 22'h1FFFFF || bus.rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL borrow_max got d=%h v=%b want 1fffff/1", bus.rsp_diff, bus.rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    bus.req_valid = '0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_vec++;
      if (bus.req_ready !== onehot(k % NREQ)) begin
        n_err++; $display("FAIL rr_grant k%0d got %b want %b", k, bus.req_ready, onehot(k % NREQ));
      end
      if (k >= 1) begin
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((k - 1) % NREQ) || bus.rsp_diff !== m_diff) begin
          n_err++;
          $display("FAIL rr_rsp k%0d got v=%b id=%0d d=%h want 1/%0d/%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_diff, (k - 1) % NREQ, m_diff);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] hold_diff;
    logic [1:0]    hold_id;
    hold_diff = m_diff;
    hold_id   = m_id;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_diff !== hold_diff || bus.rsp_id !== hold_id) begin
        n_err++;
        $display("FAIL bp_hold c%0d got rdy=%b v=%b d=%h id=%0d want 0000/1/%h/%0d",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_diff, bus.rsp_id, hold_diff, hold_id);
      end
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release got %b want 1000", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3) begin
      n_err++; $display("FAIL bp_rsp got v=%b id=%0d want 1/3", bus.rsp_valid, bus.rsp_id);
    end
  endtask

  task automatic test_mid_reset();
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL mr_setup got %b want 0100", bus.req_ready); end
    next_cycle();
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL mr_assert got rdy=%b v=%b want 0000/1", bus.req_ready, bus.rsp_valid);
    end
    next_cycle();
    #1;
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_diff !== 22'd0 || bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL mr_cleared got v=%b d=%h rdy=%b want 0/0/0000", bus.rsp_valid, bus.rsp_diff, bus.req_ready);
    end
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mr_first_grant got %b want 0010", bus.req_ready); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] v;
    int last_g;
    int wait_cnt [NREQ];
    int max_wait;
    bit acc;
    last_g   = -1;
    max_wait = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      v = bus.req_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && i != last_g) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          set_op(i, rand_op(), rand_op());
        end else begin
          v[i] = 1'b0;
        end
      end
      bus.req_valid = v;
      #1;
      n_vec++;
      if (bus.req_ready !== onehot(exp_grant())) begin
        n_err++; $display("FAIL rand_ready c%0d got %b want %b", c, bus.req_ready, onehot(exp_grant()));
      end
      n_vec++;
      if (bus.rsp_valid !== m_full || bus.rsp_diff !== m_diff || bus.rsp_id !== m_id) begin
        n_err++;
        $display("FAIL rand_rsp c%0d got v=%b d=%h id=%0d want %b/%h/%0d",
                 c, bus.rsp_valid, bus.rsp_diff, bus.rsp_id, m_full, m_diff, m_id);
      end
      last_g = exp_grant();
      acc    = rst_n && (!m_full || bus.rsp_ready);
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || i == last_g || !rst_n) wait_cnt[i] = 0;
        else if (acc) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      next_cycle();
    end
    n_vec++;
    if (max_wait >= NREQ) begin n_err++; $display("FAIL rand_fairness got max wait %0d want < %0d", max_wait, NREQ); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_borrow();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
